// File: rtl/cobs_axis_decoder.sv
// COBS stream decoder, AXI-Stream in/out, one-byte hold stage so tlast can mark the final payload byte.
// Define COBS_DECODER_ERR_COUNT_EN to add the saturating err_count output.
module cobs_axis_decoder #(
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
`ifdef COBS_DECODER_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  typedef enum logic [1:0] {HUNT, CODE, DATA} state_t;

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [7:0] remaining_q, remaining_d;
  logic       zero_pending_q, zero_pending_d;
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       err_flag_q, err_flag_d;
  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;

  logic       ready;
  logic       accept;
  logic       emit;
  logic [7:0] emit_data;
  logic       frame_end;
  logic       err_now;

  assign ready         = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && ready;
  assign s_axis_tready = ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    remaining_d    = remaining_q;
    zero_pending_d = zero_pending_q;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    err_flag_d     = err_flag_q;
    tdata_d        = tdata_q;
    tvalid_d       = tvalid_q && !m_axis_tready;
    tlast_d        = tlast_q;
    tuser_d        = tuser_q;
    emit           = 1'b0;
    emit_data      = '0;
    frame_end      = 1'b0;

    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (s_axis_tdata == 8'h00) state_d = CODE;
        end
        CODE: begin
          if (s_axis_tdata == 8'h00) begin
            frame_end = 1'b1;
          end else begin
            emit        = zero_pending_q;
            emit_data   = 8'h00;
            code_d      = s_axis_tdata;
            remaining_d = s_axis_tdata - 8'd1;
            if (s_axis_tdata == 8'h01) begin
              zero_pending_d = 1'b1;
            end else begin
              zero_pending_d = 1'b0;
              state_d        = DATA;
            end
          end
        end
        DATA: begin
          if (s_axis_tdata == 8'h00) begin
            err_flag_d = 1'b1;
            frame_end  = 1'b1;
            state_d    = CODE;
          end else begin
            emit        = 1'b1;
            emit_data   = s_axis_tdata;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              zero_pending_d = (code_q != 8'hFF);
              state_d        = CODE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_now = err_flag_d;

    // Emit and frame_end are mutually exclusive, so at most one output load per accepted byte.
    if (emit) begin
      if (hold_valid_q) begin
        tdata_d  = hold_data_q;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
      end
      hold_data_d  = emit_data;
      hold_valid_d = 1'b1;
    end

    if (frame_end) begin
      if (hold_valid_q) begin
        tdata_d  = hold_data_q;
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        tuser_d  = err_now;
      end
      hold_valid_d   = 1'b0;
      zero_pending_d = 1'b0;
      err_flag_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      code_q         <= '0;
      remaining_q    <= '0;
      zero_pending_q <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      err_flag_q     <= 1'b0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tuser_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      remaining_q    <= remaining_d;
      zero_pending_q <= zero_pending_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      err_flag_q     <= err_flag_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tuser_q        <= tuser_d;
    end
  end

`ifdef COBS_DECODER_ERR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  // Counted on every errored frame end, including ones that produce no output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (frame_end && err_now && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// Scoreboard bench for cobs_axis_decoder: directed COBS frames, expected beats queued, monitor compares handshakes.
module tb_cobs_axis_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
`ifdef COBS_DECODER_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stall_obs = 0;
  int unsigned stall_left = 0;
  bit          bp_rand = 1'b0;
  logic [9:0]  sb[$];

  cobs_axis_decoder #(.ERR_CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser)
`ifdef COBS_DECODER_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic last, input logic user);
    sb.push_back({user, last, d});
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    s_axis_tvalid = 1'b0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Downstream ready: forced stall window, optional random backpressure.
  always @(negedge clk) begin
    if (stall_left > 0) begin
      m_axis_tready = 1'b0;
      stall_left--;
    end else begin
      m_axis_tready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_axis_tvalid) begin
        if (!m_axis_tready) begin
          stall_obs++;
          chk("stall_sready", s_axis_tready, 1'b0);
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b user %0b expected none",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = sb.pop_front();
          chk("beat_data", m_axis_tdata, e[7:0]);
          chk("beat_last", m_axis_tlast, e[8]);
          chk("beat_user", m_axis_tuser, e[9]);
        end
      end
    end
  end

  initial begin
    int unsigned stall_before;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tuser", m_axis_tuser, 1'b0);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_sready", s_axis_tready, 1'b1);
`ifdef COBS_DECODER_ERR_COUNT_EN
    chk("rst_errcnt", err_count, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic frame
    expect_beat(8'h71, 1'b0, 1'b0);
    expect_beat(8'h69, 1'b1, 1'b0);
    send(8'h00); send(8'h03); send(8'h71); send(8'h69); send(8'h00);
    drain();

    // Single implied zero
    expect_beat(8'h00, 1'b1, 1'b0);
    send(8'h00); send(8'h01); send(8'h01); send(8'h00);
    drain();

    // Full 0xFF block under random backpressure: no trailing zero
    bp_rand = 1'b1;
    for (int i = 1; i <= 254; i++) expect_beat(i[7:0], (i == 254), 1'b0);
    send(8'h00); send(8'hFF);
    for (int i = 1; i <= 254; i++) send(i[7:0]);
    send(8'h00);
    drain();
    bp_rand = 1'b0;

    // Truncated block: error flagged on tlast
    expect_beat(8'hAA, 1'b0, 1'b0);
    expect_beat(8'hBB, 1'b1, 1'b1);
    send(8'h00); send(8'h04); send(8'hAA); send(8'hBB); send(8'h00);
    drain();
`ifdef COBS_DECODER_ERR_COUNT_EN
    chk("errcnt_1", err_count, 1);
`endif

    // Empty frames (one clean, one errored) produce no beats
    send(8'h01); send(8'h00); send(8'h02); send(8'h00);
    drain();
`ifdef COBS_DECODER_ERR_COUNT_EN
    chk("errcnt_2", err_count, 2);
`endif

    // Embedded zero between blocks
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h00, 1'b0, 1'b0);
    expect_beat(8'h22, 1'b1, 1'b0);
    send(8'h00); send(8'h02); send(8'h11); send(8'h02); send(8'h22); send(8'h00);
    drain();

    // Downstream stall mid-frame
    expect_beat(8'h71, 1'b0, 1'b0);
    expect_beat(8'h69, 1'b1, 1'b0);
    send(8'h00); send(8'h03); send(8'h71);
    stall_before = stall_obs;
    stall_left = 10;
    send(8'h69); send(8'h00);
    drain();
    chk("stall_seen", (stall_obs - stall_before) >= 8, 1'b1);

    // Reset mid-frame, then resync on next delimiter
    expect_beat(8'h42, 1'b1, 1'b0);
    send(8'h03); send(8'h71);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h55); send(8'h00); send(8'h02); send(8'h42); send(8'h00);
    drain();

    repeat (5) @(negedge clk);
    chk("final_tvalid", m_axis_tvalid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
